flit_inject_arbiter: RTL and testbench
======================================

# flit_inject_arbiter

Round-robin arbiter that merges `NUM_IN` AXI4 channel flit streams into the single flit stream feeding one `FlitSerializer` injection port. Multi-flit packets are never interleaved: once a non-tail flit from a requester is accepted, that requester holds the grant until its tail flit is accepted. The output is registered, which breaks the long combinational path between the AXI4 channel encoders and the serializer.

## Interface
- `NUM_IN`, default 5: number of requesters (AW, W, AR, R, B); must be ≥ 2.
- `FLIT_WIDTH`, default `AXI4S_FLIT_DATA_WIDTH + 2 + DEST_BITS + VC_BITS`: flit width. Bit `FLIT_WIDTH-1` is the valid bit and bit `FLIT_WIDTH-2` is `is_tail`.
- `CLK` input 1: clock.
- `RST_N` input 1: reset, synchronous, active-low.
- `in_flit` input `NUM_IN` x `FLIT_WIDTH`: flit from each requester (unpacked array).
- `in_valid` input `NUM_IN`: per-requester valid.
- `in_ready` output `NUM_IN`: per-requester ready. At most one bit is set.
- `out_flit` output `FLIT_WIDTH`: registered flit to the serializer.
- `out_valid` output 1: registered valid.
- `out_ready` input 1: serializer ready.
- `grant_idx` output `$clog2(NUM_IN)`: index of the requester that wrote the current output register contents (debug only).

## Operation
- **Handshake:** a transfer occurs on `valid && ready`. A requester must not deassert `in_valid` or change `in_flit` until accepted. `in_valid` must not depend on `in_ready`.
- **Output register:** a single entry.
  - `can_load = !out_valid || out_ready`.
  - `in_ready[i] = can_load && grant[i]`, where `grant` is one-hot or zero.
- **State machine:** `ARB` and `LOCK`.
  - **`ARB`:** `grant` is the first `i` with `in_valid[i]` set, scanning `ptr, ptr+1, ..., NUM_IN-1, 0, ..., ptr-1`. If none is set, `grant` is 0.
    - On an accepted flit with `is_tail=1`: `ptr <= (i+1) mod NUM_IN`; stay in `ARB`.
    - On an accepted flit with `is_tail=0`: `lock_idx <= i`; go to `LOCK`; `ptr` is unchanged.
  - **`LOCK`:** `grant = onehot(lock_idx) & in_valid`. Other requesters are stalled even if `lock_idx` is idle.
    - On an accepted tail flit: `ptr <= (lock_idx+1) mod NUM_IN`; go to `ARB`.
- **Loading the register:** when a flit is accepted, `out_flit <= in_flit[i]` (passed unmodified), `grant_idx <= i`, `out_valid <= 1`.
- **Draining the register:** when `out_ready && out_valid` and nothing is accepted in the same cycle, `out_valid <= 0`. `out_flit` holds its value.
- **Pointer arithmetic:** `ptr` and `lock_idx` are `$clog2(NUM_IN)` bits. Wrap is explicit (`NUM_IN-1` → 0), not a power-of-two overflow.

## Timing
- Latency: a flit accepted in cycle N appears on `out_flit`/`out_valid` in cycle N+1.
- Throughput: 1 flit/cycle while `out_ready` is held high.
- `out_ready` → `in_ready` is a combinational path (documented; the serializer's ready is a register decode).
- **Reset** (`RST_N=0` at the clock edge):
  - `state=ARB`, `ptr=0`, `lock_idx=0`.
  - `out_valid=0`, `out_flit=0`, `grant_idx=0`.
  - `in_ready` is forced to all-zero combinationally while `RST_N=0`.
- **Reset mid-packet:** the lock and any buffered flit are discarded. Upstream encoders are reset in the same cycle.
- **Simultaneous load and drain:** the register is overwritten and `out_valid` stays 1.
- **All requesters idle:** no state change; `ptr` is held.
- **Single-flit packets** (tail on the first flit) never enter `LOCK`.

## Structure
- Shared package `axi4_pkg`:
  - `typedef enum logic [0:0] {ARB, LOCK} inj_arb_state_t`
  - `localparam` bit positions `FLIT_VALID_BIT_OFS=1` and `FLIT_TAIL_BIT_OFS=2` (offsets from the MSB), reused by the serializer and deserializer.
- Sub-module `rr_priority_pick`: purely combinational. Takes `req[NUM_IN]` and `ptr` and returns a one-hot `gnt` and encoded `gnt_idx` using the rotate/priority-encode/rotate-back scheme. The state machine, output register and ready logic stay in the top.

## Test plan
- **Basic round-robin**, `NUM_IN=3`, `out_ready=1`. All three requesters present single-flit packets (tail=1) with data `0xA`, `0xB`, `0xC`. Required output order: A, B, C, A, … `grant_idx` sequence: 0, 1, 2, 0. One flit per cycle, first output 1 cycle after reset release.
- **Packet lock.** Requester 1 sends 3 flits (tail only on the 3rd) while requesters 0 and 2 stay valid. Required: the three req-1 flits are contiguous, then req 2 is served, then req 0. `ptr=2` after the tail.
- **Lock with bubble.** Requester 0 drops `in_valid` for 2 cycles between its flit 1 and flit 2, while req 1 is valid. Required: `in_ready[1]` stays 0 throughout; req 1 is served only after req 0's tail.
- **Backpressure.** Hold `out_ready=0` for 4 cycles with `out_valid=1`. Required: `out_flit` is stable and all `in_ready` bits are 0. On release, the held flit drains and the next flit loads in the same cycle (`out_valid` stays 1).
- **Wrap and idle.** With `ptr=2` (`NUM_IN=3`), only req 2 is valid, with tail. Required: next `ptr=0`. With no requests for 5 cycles, `ptr` stays 0 and `out_valid` falls 1 cycle after the last drain.
- **Reset mid-packet.** Assert `RST_N=0` after the 2nd flit of a 4-flit packet from req 1. Required after release: `state=ARB`, `out_valid=0`. Req 0 is granted first if valid (`ptr=0`).

Source files
------------

// File: rtl/axi4_pkg.sv
// ---------------------------------------------------------------------------
// axi4_pkg
// Definitions shared by the AXI4-over-NoC flit path: the injection arbiter,
// the FlitSerializer and the deserializer.
//   - Flit geometry: the payload width plus sideband fields set the default
//     injection flit width.
//   - Valid/tail flag positions, given as offsets from the flit MSB.
//   - Injection arbiter state encoding.
//   - rr_wrap_add: modular add for round-robin index arithmetic.
// ---------------------------------------------------------------------------
package axi4_pkg;

  localparam int AXI4S_FLIT_DATA_WIDTH = 64;
  localparam int DEST_BITS             = 3;
  localparam int VC_BITS               = 1;

  // Payload + valid + tail + destination + virtual channel.
  localparam int INJ_FLIT_WIDTH = AXI4S_FLIT_DATA_WIDTH + 2 + DEST_BITS + VC_BITS;

  // Bit FLIT_WIDTH-1 is valid and bit FLIT_WIDTH-2 is is_tail.
  localparam int FLIT_VALID_BIT_OFS = 1;
  localparam int FLIT_TAIL_BIT_OFS  = 2;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } inj_arb_state_t;

  // (base + ofs) mod modulus. Both operands are already below the modulus,
  // so a single conditional subtract is enough. This gives an explicit wrap
  // at modulus-1 instead of relying on power-of-two overflow.
  function automatic int unsigned rr_wrap_add(
    input int unsigned base,
    input int unsigned ofs,
    input int unsigned modulus
  );
    int unsigned sum;
    sum = base + ofs;
    if (sum >= modulus) begin
      sum = sum - modulus;
    end else begin
      sum = sum;
    end
    return sum;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Purely combinational round-robin pick. It returns the first set request,
// scanning ptr, ptr+1, ..., NUM_IN-1, 0, ..., ptr-1.
// The scan works in three steps: rotate the request vector so that ptr sits
// at bit 0, priority-encode the lowest set bit, then rotate the result back.
// Ports:
//   req     in  [NUM_IN]  request vector
//   ptr     in  [IDXW]    highest-priority position, always < NUM_IN
//   gnt     out [NUM_IN]  one-hot grant, all-zero when there is no request
//   gnt_idx out [IDXW]    encoded grant, equal to ptr when there is no request
// ---------------------------------------------------------------------------
module rr_priority_pick
  import axi4_pkg::*;
#(
  parameter int NUM_IN = 5,
  localparam int IDXW = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDXW-1:0]   ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [IDXW-1:0]   gnt_idx
);

  logic [NUM_IN-1:0] w_rot;
  logic [IDXW-1:0]   w_ofs;
  logic              w_hit;

  // Rotate requests so that position ptr lands at bit 0.
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_rot[k] = req[IDXW'(rr_wrap_add(32'(ptr), k, NUM_IN))];
    end
  end

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    w_hit = 1'b0;
    w_ofs = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!w_hit && w_rot[k]) begin
        w_hit = 1'b1;
        w_ofs = IDXW'(k);
      end else begin
        w_hit = w_hit;
        w_ofs = w_ofs;
      end
    end
  end

  // Rotate the winning offset back into requester numbering.
  always_comb begin
    gnt_idx = IDXW'(rr_wrap_add(32'(w_ofs), 32'(ptr), NUM_IN));
    if (w_hit) begin
      gnt = {{(NUM_IN-1){1'b0}}, 1'b1} << gnt_idx;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/flit_inject_arbiter.sv
// ---------------------------------------------------------------------------
// flit_inject_arbiter
// Merges NUM_IN AXI4 channel flit streams (AW, W, AR, R, B) into the single
// stream that feeds one FlitSerializer injection port.
//   - Arbitration is round-robin.
//   - Multi-flit packets are never interleaved: after a non-tail flit is
//     accepted, the same requester keeps the grant until its tail flit is
//     accepted.
//   - A one-entry output register breaks the combinational path from the
//     channel encoders to the serializer.
//   - out_ready reaches in_ready combinationally. The serializer's ready is a
//     register decode, so this path is short.
// Ports:
//   CLK        in                 clock
//   RST_N      in                 synchronous active-low reset
//   in_flit    in  [NUM_IN][FW]   flit from each requester
//   in_valid   in  [NUM_IN]       per-requester valid
//   in_ready   out [NUM_IN]       per-requester ready, at most one bit set
//   out_flit   out [FW]           registered flit to the serializer
//   out_valid  out                registered valid
//   out_ready  in                 serializer ready
//   grant_idx  out [IDXW]         requester that wrote out_flit (debug only)
// ---------------------------------------------------------------------------
module flit_inject_arbiter
  import axi4_pkg::*;
#(
  parameter int NUM_IN     = 5,
  parameter int FLIT_WIDTH = INJ_FLIT_WIDTH,
  localparam int IDXW      = $clog2(NUM_IN)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [FLIT_WIDTH-1:0] in_flit [NUM_IN],
  input  logic [NUM_IN-1:0]     in_valid,
  output logic [NUM_IN-1:0]     in_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDXW-1:0]       grant_idx
);

  inj_arb_state_t        r_state;
  logic [IDXW-1:0]       r_ptr;
  logic [IDXW-1:0]       r_lock_idx;
  logic [FLIT_WIDTH-1:0] r_out_flit;
  logic                  r_out_valid;
  logic [IDXW-1:0]       r_grant_idx;

  logic [NUM_IN-1:0]     w_pick_gnt;
  logic [IDXW-1:0]       w_pick_idx;
  logic [NUM_IN-1:0]     w_lock_onehot;
  logic [NUM_IN-1:0]     w_grant;
  logic [IDXW-1:0]       w_grant_idx;
  logic                  w_can_load;
  logic                  w_accept;
  logic [FLIT_WIDTH-1:0] w_sel_flit;
  logic                  w_sel_tail;

  rr_priority_pick #(
    .NUM_IN (NUM_IN)
  ) u_pick (
    .req     (in_valid),
    .ptr     (r_ptr),
    .gnt     (w_pick_gnt),
    .gnt_idx (w_pick_idx)
  );

  assign w_lock_onehot = {{(NUM_IN-1){1'b0}}, 1'b1} << r_lock_idx;

  // In LOCK, only the owner of the open packet can be granted. Everyone else
  // stalls, even while the owner is idle between flits.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    case (r_state)
      ARB: begin
        w_grant     = w_pick_gnt;
        w_grant_idx = w_pick_idx;
      end
      LOCK: begin
        w_grant     = w_lock_onehot & in_valid;
        w_grant_idx = r_lock_idx;
      end
      default: begin
        w_grant     = '0;
        w_grant_idx = '0;
      end
    endcase
  end

  // The register can take a new flit when it is empty or is being drained.
  assign w_can_load = !r_out_valid || out_ready;

  // Ready stays low while reset is asserted, so nothing is handshaken during reset.
  always_comb begin
    if (RST_N && w_can_load) begin
      in_ready = w_grant;
    end else begin
      in_ready = '0;
    end
  end

  // w_grant is a subset of in_valid, so any ready bit means a transfer.
  assign w_accept   = |in_ready;
  assign w_sel_flit = in_flit[w_grant_idx];
  assign w_sel_tail = w_sel_flit[FLIT_WIDTH-FLIT_TAIL_BIT_OFS];

  // This block holds the arbitration state machine, the round-robin pointer
  // and the output register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= ARB;
      r_ptr       <= '0;
      r_lock_idx  <= '0;
      r_out_flit  <= '0;
      r_out_valid <= 1'b0;
      r_grant_idx <= '0;
    end else begin
      if (w_accept) begin
        r_out_flit  <= w_sel_flit;
        r_grant_idx <= w_grant_idx;
        r_out_valid <= 1'b1;
        case (r_state)
          ARB: begin
            if (w_sel_tail) begin
              r_ptr <= IDXW'(rr_wrap_add(32'(w_grant_idx), 32'd1, NUM_IN));
            end else begin
              r_lock_idx <= w_grant_idx;
              r_state    <= LOCK;
            end
          end
          LOCK: begin
            if (w_sel_tail) begin
              r_ptr   <= IDXW'(rr_wrap_add(32'(r_lock_idx), 32'd1, NUM_IN));
              r_state <= ARB;
            end else begin
              r_state <= LOCK;
            end
          end
          default: begin
            r_state <= ARB;
          end
        endcase
      end else if (out_ready) begin
        // Drain without refill. out_flit keeps its last value.
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign out_flit  = r_out_flit;
  assign out_valid = r_out_valid;
  assign grant_idx = r_grant_idx;

endmodule

// File: tb/tb_flit_inject_arbiter.sv
// ---------------------------------------------------------------------------
// tb_flit_inject_arbiter
// Directed bench for flit_inject_arbiter with NUM_IN=3.
//   - Each requester is modelled as a queue that holds its flit until the
//     arbiter accepts it.
//   - The expected output order is pushed to a scoreboard as stimulus is
//     issued.
//   - An entry is popped and compared each time the serializer side consumes
//     a flit (out_valid && out_ready).
// ---------------------------------------------------------------------------
module tb_flit_inject_arbiter;
  import axi4_pkg::*;

  localparam int NI = 3;
  localparam int FW = INJ_FLIT_WIDTH;

  typedef struct packed {
    logic [1:0]    idx;
    logic [FW-1:0] flit;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [FW-1:0] in_flit [NI];
  logic [NI-1:0] in_valid;
  logic [NI-1:0] in_ready;
  logic [FW-1:0] out_flit;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    grant_idx;

  logic [FW-1:0] q0 [$];
  logic [FW-1:0] q1 [$];
  logic [FW-1:0] q2 [$];
  exp_t          exp_q [$];
  logic [NI-1:0] blk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  flit_inject_arbiter #(
    .NUM_IN     (NI),
    .FLIT_WIDTH (FW)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_idx (grant_idx)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [7:0] tag, input logic tail);
    logic [FW-1:0] f;
    f          = '0;
    f[FW-1]    = 1'b1;
    f[FW-2]    = tail;
    f[FW-3 -: 8] = ~tag;
    f[7:0]     = tag;
    return f;
  endfunction

  task automatic push_src(input int r, input logic [FW-1:0] f);
    case (r)
      0: q0.push_back(f);
      1: q1.push_back(f);
      2: q2.push_back(f);
      default: ;
    endcase
  endtask

  task automatic push_exp(input int r, input logic [FW-1:0] f);
    exp_t e;
    e.idx  = 2'(r);
    e.flit = f;
    exp_q.push_back(e);
  endtask

  // Source and scoreboard entry in one call.
  task automatic send(input int r, input logic [7:0] tag, input logic tail);
    push_src(r, mk(tag, tail));
    push_exp(r, mk(tag, tail));
  endtask

  task automatic present();
    in_valid[0] = (q0.size() > 0) && !blk[0];
    in_valid[1] = (q1.size() > 0) && !blk[1];
    in_valid[2] = (q2.size() > 0) && !blk[2];
    if (q0.size() > 0) in_flit[0] = q0[0];
    if (q1.size() > 0) in_flit[1] = q1[0];
    if (q2.size() > 0) in_flit[2] = q2[0];
  endtask

  // One clock: sample at the negedge, then update the sources after the posedge.
  task automatic tick();
    logic [NI-1:0] acc;
    exp_t          e;
    @(negedge CLK);
    acc = in_valid & in_ready;
    chk("ready_onehot", 128'($countones(in_ready) <= 1), 128'd1);
    if (RST_N && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", out_flit, 128'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_flit", out_flit, e.flit);
        chk("grant_idx", grant_idx, e.idx);
      end
    end
    @(posedge CLK);
    #1;
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
    if (acc[2]) void'(q2.pop_front());
    present();
  endtask

  task automatic run_until_empty(input int budget, output int used);
    used = 0;
    while (exp_q.size() > 0 && used < budget) begin
      tick();
      used++;
    end
    chk("drain_done", exp_q.size(), 128'd0);
  endtask

  initial begin
    int n;
    RST_N     = 1'b0;
    out_ready = 1'b1;
    blk       = '0;
    in_valid  = '0;
    for (int i = 0; i < NI; i++) in_flit[i] = '0;

    // Reset: requesters are already valid but must see no ready.
    push_src(0, mk(8'h0A, 1'b1)); push_src(0, mk(8'h0A, 1'b1));
    push_src(1, mk(8'h0B, 1'b1)); push_src(1, mk(8'h0B, 1'b1));
    push_src(2, mk(8'h0C, 1'b1)); push_src(2, mk(8'h0C, 1'b1));
    present();
    #2;
    chk("rst_in_ready", in_ready, 128'd0);
    tick();
    tick();
    chk("rst_out_valid", out_valid, 128'd0);
    chk("rst_out_flit", out_flit, 128'd0);
    chk("rst_grant_idx", grant_idx, 128'd0);
    chk("rst_state", dut.r_state, ARB);
    chk("rst_ptr", dut.r_ptr, 128'd0);

    // Basic round-robin.
    RST_N = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push_exp(0, mk(8'h0A, 1'b1));
      push_exp(1, mk(8'h0B, 1'b1));
      push_exp(2, mk(8'h0C, 1'b1));
    end
    tick();
    chk("first_latency", out_valid, 128'd1);
    run_until_empty(20, n);
    chk("rr_throughput", n, 128'd6);
    chk("rr_ptr", dut.r_ptr, 128'd0);

    // Packet lock: first move ptr to 1.
    send(0, 8'h50, 1'b1);
    present();
    run_until_empty(10, n);
    chk("lock_pre_ptr", dut.r_ptr, 128'd1);
    send(1, 8'h11, 1'b0);
    send(1, 8'h12, 1'b0);
    send(1, 8'h13, 1'b1);
    send(2, 8'h2D, 1'b1);
    send(0, 8'h0D, 1'b1);
    present();
    tick(); tick(); tick();
    chk("lock_ptr_after_tail", dut.r_ptr, 128'd2);
    chk("lock_state_after_tail", dut.r_state, ARB);
    run_until_empty(20, n);
    chk("lock_end_ptr", dut.r_ptr, 128'd1);

    // Lock with a bubble from requester 0.
    send(0, 8'hF1, 1'b0);
    present();
    tick();
    chk("bubble_state", dut.r_state, LOCK);
    blk[0] = 1'b1;
    push_src(0, mk(8'hF2, 1'b1));
    push_src(1, mk(8'hB1, 1'b1));
    present();
    #1;
    chk("bubble_ready_0", in_ready, 128'd0);
    tick();
    #1;
    chk("bubble_ready_1", in_ready, 128'd0);
    tick();
    #1;
    chk("bubble_ready_2", in_ready, 128'd0);
    blk[0] = 1'b0;
    present();
    #1;
    chk("bubble_resume_ready", in_ready, 128'd1);
    push_exp(0, mk(8'hF2, 1'b1));
    push_exp(1, mk(8'hB1, 1'b1));
    run_until_empty(20, n);
    chk("bubble_ptr", dut.r_ptr, 128'd2);

    // Backpressure.
    send(2, 8'h77, 1'b1);
    send(0, 8'h78, 1'b1);
    present();
    tick();
    out_ready = 1'b0;
    #1;
    chk("bp_ready_start", in_ready, 128'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_flit_stable", out_flit, mk(8'h77, 1'b1));
      chk("bp_valid", out_valid, 128'd1);
      chk("bp_ready", in_ready, 128'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_reload_valid", out_valid, 128'd1);
    chk("bp_reload_flit", out_flit, mk(8'h78, 1'b1));
    run_until_empty(10, n);

    // Wrap and idle.
    send(1, 8'h21, 1'b1);
    present();
    run_until_empty(10, n);
    chk("wrap_pre_ptr", dut.r_ptr, 128'd2);
    send(2, 8'h22, 1'b1);
    present();
    run_until_empty(10, n);
    chk("wrap_ptr", dut.r_ptr, 128'd0);
    chk("idle_valid_fall", out_valid, 128'd0);
    for (int k = 0; k < 5; k++) tick();
    chk("idle_ptr", dut.r_ptr, 128'd0);
    chk("idle_valid", out_valid, 128'd0);

    // Reset mid-packet.
    push_src(1, mk(8'hC1, 1'b0));
    push_src(1, mk(8'hC2, 1'b0));
    push_src(1, mk(8'hC3, 1'b0));
    push_src(1, mk(8'hC4, 1'b1));
    push_exp(1, mk(8'hC1, 1'b0));
    present();
    tick();
    tick();
    chk("mid_lock_state", dut.r_state, LOCK);
    RST_N = 1'b0;
    q1.delete();
    exp_q.delete();
    push_src(0, mk(8'hD0, 1'b1));
    push_src(1, mk(8'hD1, 1'b1));
    present();
    #1;
    chk("mid_rst_ready", in_ready, 128'd0);
    tick();
    chk("mid_rst_state", dut.r_state, ARB);
    chk("mid_rst_valid", out_valid, 128'd0);
    chk("mid_rst_ptr", dut.r_ptr, 128'd0);
    RST_N = 1'b1;
    push_exp(0, mk(8'hD0, 1'b1));
    push_exp(1, mk(8'hD1, 1'b1));
    tick();
    chk("mid_first_grant", grant_idx, 128'd0);
    run_until_empty(10, n);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
